interp_rate_scheduler: RTL and testbench

//  Sequences the linear interpolator for asynchronous sample-rate conversion. Divides the master clock to the 96 kHz output tick.

---
 rtl/interp_rate_scheduler.sv | 187 ++++++++++++++++++
 tb/tb_interp_rate_scheduler.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/interp_rate_scheduler.sv
// interp_rate_scheduler
//   Sequences a linear interpolator for asynchronous sample-rate conversion.
//   Divides clk down to the output-sample tick. On each tick the block advances a
//   fixed-point phase accumulator by the ratio word and pulls the whole-sample
//   carry from the input FIFO. It then issues the sub-sample fraction with a
//   start strobe and waits for the interpolator to finish.
//   Optional build macro: INTERP_SCHED_STATS_EN adds the err_count output.
module interp_rate_scheduler #(
    parameter int OUT_DIV = 512,
    parameter int PHASE_W = 10,
    parameter int STEP_W  = 16
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               run,
    input  logic [STEP_W-1:0]  step,
    input  logic               fifo_valid,
    output logic               fifo_rd,
    output logic               samp_load,
    output logic [PHASE_W-1:0] sub_sample_cnt,
    output logic               interp_start,
    input  logic               interp_done,
    output logic               busy,
    output logic               underrun,
    output logic               overrun
`ifdef INTERP_SCHED_STATS_EN
    ,
    output logic [15:0]        err_count
`endif
);

    localparam int CNT_W  = (OUT_DIV > 1) ? $clog2(OUT_DIV) : 1;
    localparam int NEED_W = STEP_W - PHASE_W + 1;
    localparam logic [CNT_W-1:0] TICK_AT = CNT_W'(OUT_DIV - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADVANCE,
        S_FETCH,
        S_START,
        S_WAIT
    } state_t;

    state_t             r_state;
    logic [CNT_W-1:0]   r_tick_cnt;
    logic [PHASE_W-1:0] r_phase;
    logic [NEED_W-1:0]  r_need;
    logic [PHASE_W-1:0] r_sub;
    logic               r_samp_load;
    logic               r_interp_start;
    logic               r_busy;
    logic               r_underrun;
    logic               r_overrun;

    logic               w_tick;
    logic               w_take;
    logic               w_under_ev;
    logic               w_over_ev;
    logic [STEP_W:0]    w_acc;
    logic [NEED_W-1:0]  w_need;

    // Output-rate divider: free-runs while enabled, parked at zero otherwise.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_tick_cnt <= '0;
        end else if (!run) begin
            r_tick_cnt <= '0;
        end else if (r_tick_cnt == TICK_AT) begin
            r_tick_cnt <= '0;
        end else begin
            r_tick_cnt <= r_tick_cnt + 1'b1;
        end
    end

    assign w_tick = run && (r_tick_cnt == TICK_AT);

    // Phase plus ratio; the integer part is how many new samples to pull.
    assign w_acc  = {{(STEP_W + 1 - PHASE_W){1'b0}}, r_phase} + {1'b0, step};
    assign w_need = w_acc[STEP_W:PHASE_W];

    // Read strobe is combinational so a sample is taken in the same clk it is offered.
    assign fifo_rd = run && (r_state == S_FETCH) && fifo_valid;
    assign w_take  = fifo_rd;

    // A tick is only lost when the FSM is still busy; a tick coinciding with
    // interp_done is treated as if IDLE had seen it.
    assign w_over_ev  = w_tick && (r_state != S_IDLE) && !((r_state == S_WAIT) && interp_done);
    assign w_under_ev = w_tick && (r_state == S_FETCH) && !fifo_valid;

    // Main sequencer with registered strobes and status.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state        <= S_IDLE;
            r_phase        <= '0;
            r_need         <= '0;
            r_sub          <= '0;
            r_samp_load    <= 1'b0;
            r_interp_start <= 1'b0;
            r_busy         <= 1'b0;
            r_underrun     <= 1'b0;
            r_overrun      <= 1'b0;
        end else if (!run) begin
            r_state        <= S_IDLE;
            r_phase        <= '0;
            r_need         <= '0;
            r_samp_load    <= 1'b0;
            r_interp_start <= 1'b0;
            r_busy         <= 1'b0;
            r_underrun     <= 1'b0;
            r_overrun      <= 1'b0;
        end else begin
            r_samp_load    <= w_take;
            r_interp_start <= 1'b0;
            r_underrun     <= w_under_ev;
            r_overrun      <= w_over_ev;
            case (r_state)
                S_IDLE: begin
                    if (w_tick) begin
                        r_state <= S_ADVANCE;
                        r_busy  <= 1'b1;
                    end
                end
                S_ADVANCE: begin
                    r_phase <= w_acc[PHASE_W-1:0];
                    r_need  <= w_need;
                    r_state <= (w_need == '0) ? S_START : S_FETCH;
                end
                S_FETCH: begin
                    if (w_tick) begin
                        // Out of time: reuse the samples already held.
                        r_need  <= '0;
                        r_state <= S_START;
                    end else if (w_take) begin
                        r_need <= r_need - 1'b1;
                        if (r_need == NEED_W'(1)) begin
                            r_state <= S_START;
                        end
                    end
                end
                S_START: begin
                    r_sub          <= r_phase;
                    r_interp_start <= 1'b1;
                    r_state        <= S_WAIT;
                end
                S_WAIT: begin
                    if (interp_done) begin
                        if (w_tick) begin
                            r_state <= S_ADVANCE;
                        end else begin
                            r_state <= S_IDLE;
                            r_busy  <= 1'b0;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign samp_load      = r_samp_load;
    assign sub_sample_cnt = r_sub;
    assign interp_start   = r_interp_start;
    assign busy           = r_busy;
    assign underrun       = r_underrun;
    assign overrun        = r_overrun;

`ifdef INTERP_SCHED_STATS_EN
    logic [15:0] r_err_count;

    // Saturating error tally; a clk with both faults counts once.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_err_count <= '0;
        end else if (!run) begin
            r_err_count <= '0;
        end else if ((w_under_ev || w_over_ev) && (r_err_count != 16'hFFFF)) begin
            r_err_count <= r_err_count + 16'd1;
        end
    end

    assign err_count = r_err_count;
`endif

endmodule

// File: tb/tb_interp_rate_scheduler.sv
// Testbench for interp_rate_scheduler: the stimulus pushes one expected record
// per output tick, and a monitor pops it at every interp_start.
module tb_interp_rate_scheduler;

    localparam int OUT_DIV = 512;
    localparam int PHASE_W = 10;
    localparam int STEP_W  = 16;
    localparam int PH_MOD  = 1 << PHASE_W;

    logic               clk = 1'b0;
    logic               reset_n = 1'b0;
    logic               run = 1'b0;
    logic [STEP_W-1:0]  step = '0;
    logic               fifo_valid = 1'b0;
    logic               interp_done = 1'b0;
    logic               fifo_rd;
    logic               samp_load;
    logic [PHASE_W-1:0] sub_sample_cnt;
    logic               interp_start;
    logic               busy;
    logic               underrun;
    logic               overrun;
`ifdef INTERP_SCHED_STATS_EN
    logic [15:0]        err_count;
`endif

    always #5 clk = ~clk;

    interp_rate_scheduler #(
        .OUT_DIV (OUT_DIV),
        .PHASE_W (PHASE_W),
        .STEP_W  (STEP_W)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .run            (run),
        .step           (step),
        .fifo_valid     (fifo_valid),
        .fifo_rd        (fifo_rd),
        .samp_load      (samp_load),
        .sub_sample_cnt (sub_sample_cnt),
        .interp_start   (interp_start),
        .interp_done    (interp_done),
        .busy           (busy),
        .underrun       (underrun),
        .overrun        (overrun)
`ifdef INTERP_SCHED_STATS_EN
        ,
        .err_count      (err_count)
`endif
    );

    typedef struct {
        int sub;
        int loads;
        int lat;
        int under;
        int over;
        int both;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   gcyc     = 0;
    int   tb_cyc   = 0;
    int   done_delay = 10;
    int   m_phase  = 0;
    int   pend_over = 0;
    logic tb_tick;

    // Reference time base: cycles since run went high, tick on the last of every OUT_DIV.
    always @(posedge clk) begin
        gcyc <= gcyc + 1;
        if (!run) tb_cyc <= 0;
        else      tb_cyc <= tb_cyc + 1;
    end
    assign tb_tick = run && ((tb_cyc % OUT_DIV) == (OUT_DIV - 1));

    task automatic chk(input string name, input int got, input int expv);
        n_checks++;
        if (got == expv) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, expv, $time);
    endtask

    task automatic wait_tick(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 1200; i++) begin
            @(negedge clk);
            if (tb_tick) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("tick_timeout", 0, 1);
    endtask

    // One ordinary output period: FIFO always full, done after dly clks.
    task automatic do_frame(input logic [STEP_W-1:0] st, input int dly);
        bit   ok;
        int   acc;
        int   need;
        exp_t e;
        @(negedge clk);
        step       = st;
        done_delay = dly;
        fifo_valid = 1'b1;
        wait_tick(ok);
        if (ok) begin
            chk("idle_at_tick", int'(busy), 0);
            acc     = m_phase + int'(st);
            need    = acc / PH_MOD;
            m_phase = acc % PH_MOD;
            e.sub   = m_phase;
            e.loads = need;
            e.lat   = 3 + need;
            e.under = 0;
            e.over  = pend_over;
            e.both  = 0;
            pend_over = 0;
            exp_q.push_back(e);
        end
        repeat (50) @(negedge clk);
    endtask

    // Interpolator stand-in: answers each start after done_delay clks.
    initial begin
        int d;
        forever begin
            @(negedge clk);
            if (interp_start && reset_n) begin
                d = (done_delay < 1) ? 1 : done_delay;
                repeat (d - 1) @(negedge clk);
                interp_done = 1'b1;
                @(negedge clk);
                interp_done = 1'b0;
            end
        end
    end

    // Monitor: tallies activity between starts, checks it when a start appears.
    initial begin
        int   last_tick;
        int   n_load;
        int   n_rd;
        int   n_under;
        int   n_over;
        int   n_both;
        int   n_txn;
        exp_t e;
        last_tick = 0; n_load = 0; n_rd = 0; n_under = 0; n_over = 0; n_both = 0; n_txn = 0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                n_load = 0; n_rd = 0; n_under = 0; n_over = 0; n_both = 0;
            end else begin
                if (tb_tick) last_tick = gcyc;
                if (samp_load) n_load++;
                if (fifo_rd) n_rd++;
                if (underrun) n_under++;
                if (overrun) n_over++;
                if (underrun && overrun) n_both++;
                if (interp_start) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_start", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("sub_sample_cnt", int'(sub_sample_cnt), e.sub);
                        chk("samp_load_count", n_load, e.loads);
                        chk("fifo_rd_cycles", n_rd, e.loads);
                        chk("start_latency", gcyc - last_tick, e.lat);
                        chk("underrun_count", n_under, e.under);
                        chk("overrun_count", n_over, e.over);
                        chk("under_over_same_clk", n_both, e.both);
                        $display("txn %0d: sub=%03h loads=%0d lat=%0d under=%0d over=%0d",
                                 n_txn, sub_sample_cnt, n_load, gcyc - last_tick, n_under, n_over);
                    end
                    n_txn++;
                    n_load = 0; n_rd = 0; n_under = 0; n_over = 0; n_both = 0;
                end
            end
        end
    end

    task automatic chk_all_zero(input string tag);
        chk({tag, "_fifo_rd"}, int'(fifo_rd), 0);
        chk({tag, "_samp_load"}, int'(samp_load), 0);
        chk({tag, "_sub"}, int'(sub_sample_cnt), 0);
        chk({tag, "_start"}, int'(interp_start), 0);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_underrun"}, int'(underrun), 0);
        chk({tag, "_overrun"}, int'(overrun), 0);
    endtask

    // Stimulus
    initial begin
        bit   ok;
        int   acc;
        exp_t e;
        logic [STEP_W-1:0] st;

        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        reset_n = 1'b1;
        @(negedge clk);
        run = 1'b1;

        // Unity ratio: one fetch per tick, fraction stays 0.
        repeat (3) do_frame(16'h0400, 10);
        // Half ratio: fetch counts alternate 0,1.
        repeat (4) do_frame(16'h0200, 10);
        // Ratio 3: three fetch clks, start 6 clk after tick.
        repeat (2) do_frame(16'h0C00, 10);

        // Random ratios, including step==0.
        for (int i = 0; i < 12; i++) begin
            if (i % 4 == 3) st = '0;
            else            st = STEP_W'($urandom_range(0, 32'h17FF));
            do_frame(st, int'($urandom_range(1, 20)));
        end

        // FIFO empties at the tick: the next tick abandons the fetch.
        @(negedge clk);
        step = 16'h0400; done_delay = 10; fifo_valid = 1'b1;
        wait_tick(ok);
        fifo_valid = 1'b0;
        acc     = m_phase + 32'h400;
        m_phase = acc % PH_MOD;
        wait_tick(ok);
        e.sub = m_phase; e.loads = 0; e.lat = 2; e.under = 1; e.over = 1; e.both = 1;
        exp_q.push_back(e);
        repeat (50) @(negedge clk);
        do_frame(16'h0400, 10);

        // Slow interpolator: the tick inside WAIT is dropped with one overrun.
        do_frame(16'h0400, 600);
        wait_tick(ok);
        pend_over = pend_over + 1;
        done_delay = 10;
        repeat (50) @(negedge clk);
        do_frame(16'h0400, 10);

        // Land the phase on 0x200, then reset in the middle of a 2-sample fetch.
        do_frame(STEP_W'(32'h400 + ((32'h200 - m_phase) & 32'h3FF)), 8);
        @(negedge clk);
        step = 16'h0800; fifo_valid = 1'b0;
        wait_tick(ok);
        repeat (3) @(negedge clk);
        chk("busy_in_fetch", int'(busy), 1);
        chk("sub_before_reset", int'(sub_sample_cnt), 32'h200);
        reset_n = 1'b0;
        run     = 1'b0;
        #1;
        chk_all_zero("midfetch_reset");
        exp_q.delete();
        m_phase   = 0;
        pend_over = 0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        run = 1'b1;
        do_frame(16'h0400, 10);

        repeat (100) @(negedge clk);
        chk("queue_drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation ran past its time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
